// File: rtl/alu_nibble_sequencer.sv
// Multi-cycle W-bit ALU sequencer: runs one 4-bit slice per clock, LSB nibble first,
// with a registered ripple carry and valid/ready handshakes on both sides.
module alu_nibble_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic [2:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_result,
    output logic                 out_cout,
    output logic                 out_overflow,
    output logic                 out_zero
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [W-1:0]    a_sh, b_sh;
    logic [W-5:0]    res_sh;
    logic [2:0]      op;
    logic [IW-1:0]   idx;
    logic            carry;

    logic            in_inv, last;
    logic [3:0]      a_nib, b_nib, nib_res;
    logic [4:0]      sum5;
    logic            c_msb_in, ovf;
    logic [W-1:0]    res_next, fin_result;
    logic            fin_cout, fin_ovf;

    assign in_inv = (in_op == OP_SUB) || (in_op == OP_SLT);
    assign last   = (idx == IW'(NIBBLES - 1));

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // b is stored pre-inverted for SUB/SLT, so the slice always adds
    always_comb begin
        a_nib    = a_sh[3:0];
        b_nib    = b_sh[3:0];
        sum5     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry};
        c_msb_in = a_nib[3] ^ b_nib[3] ^ sum5[3];
        ovf      = c_msb_in ^ sum5[4];
        case (op)
            OP_AND:                 nib_res = a_nib & b_nib;
            OP_OR:                  nib_res = a_nib | b_nib;
            OP_ADD, OP_SUB, OP_SLT: nib_res = sum5[3:0];
            default:                nib_res = 4'b0;
        endcase
        res_next = {nib_res, res_sh};

        fin_result = '0;
        fin_cout   = 1'b0;
        fin_ovf    = 1'b0;
        case (op)
            OP_AND, OP_OR: fin_result = res_next;
            OP_ADD, OP_SUB: begin
                fin_result = res_next;
                fin_cout   = sum5[4];
                fin_ovf    = ovf;
            end
            OP_SLT: begin
                fin_result = {{(W-1){1'b0}}, res_next[W-1] ^ ovf};
                fin_cout   = sum5[4];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            a_sh         <= '0;
            b_sh         <= '0;
            res_sh       <= '0;
            op           <= '0;
            idx          <= '0;
            carry        <= 1'b0;
            out_result   <= '0;
            out_cout     <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= in_a;
                        b_sh   <= in_inv ? ~in_b : in_b;
                        op     <= in_op;
                        idx    <= '0;
                        carry  <= in_inv;
                        res_sh <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= {4'b0, a_sh[W-1:4]};
                    b_sh   <= {4'b0, b_sh[W-1:4]};
                    res_sh <= res_next[W-1:4];
                    carry  <= sum5[4];
                    idx    <= idx + IW'(1);
                    if (last) begin
                        out_result   <= fin_result;
                        out_cout     <= fin_cout;
                        out_overflow <= fin_ovf;
                        out_zero     <= (fin_result == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Randomized self-checking bench for alu_nibble_sequencer against a plain-arithmetic
// reference model, plus directed corner, backpressure and mid-operation reset cases.
module tb_alu_nibble_sequencer;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic [2:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_cout, out_overflow, out_zero;

    int n_cmp = 0;
    int n_bad = 0;

    alu_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_cout     (out_cout),
        .out_overflow (out_overflow),
        .out_zero     (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {zero, overflow, cout, result}
    function automatic logic [W+2:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b110: begin
                r = a - b;
                c = (a >= b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b111: begin
                r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
                c = (a >= b);
            end
            default: ;
        endcase
        return {(r == '0), v, c, r};
    endfunction

    task automatic check_outputs(input string tag, input logic [W+2:0] exp);
        check({tag, "_result"},   32'(out_result),   32'(exp[W-1:0]));
        check({tag, "_cout"},     32'(out_cout),     32'(exp[W]));
        check({tag, "_overflow"}, 32'(out_overflow), 32'(exp[W+1]));
        check({tag, "_zero"},     32'(out_zero),     32'(exp[W+2]));
    endtask

    task automatic wait_result(input string tag, input logic [W+2:0] exp);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(N));
        check_outputs(tag, exp);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W+2:0] exp;
        int cyc;
        exp      = model(op, a, b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_op    = 3'($urandom);
        wait_result(tag, exp);
        repeat (hold) begin
            tick();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_outputs({tag, "_hold"}, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [W+2:0] exp;
        logic [W-1:0] ra, rb;
        logic [2:0]   rop;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_outputs("rst", '0);

        run_op("add_ovf",   3'b010, 16'h7FFF, 16'h0001, 0);
        run_op("sub_eq",    3'b110, 16'h0005, 16'h0005, 0);
        run_op("add_wrap",  3'b010, 16'hFFFF, 16'h0001, 0);
        run_op("slt_ovf",   3'b111, 16'h8000, 16'h7FFF, 0);
        run_op("slt_neg",   3'b111, 16'h0003, 16'hFFFF, 0);
        run_op("slt_m1",    3'b111, 16'hFFFF, 16'h0001, 0);
        run_op("and",       3'b000, 16'hF0F0, 16'h3C3C, 0);
        run_op("or",        3'b001, 16'hF0F0, 16'h0F0F, 0);
        run_op("reserved",  3'b011, 16'h1234, 16'h4321, 0);

        // Backpressure: a new request waits while the previous response is stalled
        exp      = model(3'b010, 16'h1111, 16'h2222);
        in_valid = 1'b1;
        in_a     = 16'h1111;
        in_b     = 16'h2222;
        in_op    = 3'b010;
        tick();
        in_a     = 16'hABCD;
        in_b     = 16'h1234;
        in_op    = 3'b110;
        wait_result("bp_first", exp);
        repeat (3) begin
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check_outputs("bp_stable", exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_accepted", 32'(in_ready), 32'd0);
        wait_result("bp_second", model(3'b110, 16'hABCD, 16'h1234));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during RUN at nibble index 2
        in_valid = 1'b1;
        in_a     = 16'h4444;
        in_b     = 16'h5555;
        in_op    = 3'b010;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        repeat (N + 1) begin
            tick();
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        run_op("post_abort", 3'b010, 16'h1234, 16'h1111, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = W'($urandom);
            rb  = W'($urandom);
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = 16'h8000;
                2: rb = 16'h7FFF;
                default: ;
            endcase
            run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
Multi-cycle controller that executes W-bit ALU operations on the team's 4-bit ALU slice, one nibble per clock, LSB nibble first. It holds the operands and the inter-nibble carry, collects result nibbles, and derives the final cout/overflow/zero/SLT result. It sits between an issue stage (valid/ready request) and a writeback stage (valid/ready response). It lets narrow-datapath builds run full-width integer ops with one shared slice.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES (legal 2..8)

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high; sampled on rising clk
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready at a rising edge
in_a  in  W  operand A
in_b  in  W  operand B
in_op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed); others reserved
out_valid  out  1  response valid
out_ready  in  1  response consumed when out_valid & out_ready at a rising edge
out_result  out  W  operation result
out_cout  out  1  carry out of MSB (ADD/SUB/SLT), else 0
out_overflow  out  1  signed overflow (ADD/SUB only), else 0
out_zero  out  1  1 iff out_result == 0

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- States: IDLE, RUN, DONE. Reset forces IDLE, nibble index 0, carry 0, and all out_* registers 0. in_ready = (state==IDLE), so it is 1 after reset. out_valid = (state==DONE).
- IDLE: on the in_valid & in_ready edge, latch a, b and op. Clear the index. Carry init = 1 for SUB/SLT (invert b), else 0. Go to RUN. in_a/in_b/in_op are don't-care at any other time.
- RUN, nibble i per cycle:
  - Apply a[4i+3:4i], b[4i+3:4i] (b inverted for SUB/SLT) and the carry.
  - Register the result nibble and the new carry.
  - When i == NIBBLES-1, go to DONE. Otherwise i <= i+1.
  - Carry between nibbles is a registered ripple; no lookahead across nibbles.
- Finalize on the last RUN edge:
  - cout = final carry.
  - overflow = carry into MSB XOR carry out of MSB.
  - ADD/SUB: result = assembled nibbles, overflow as computed.
  - SLT: lt = sum[W-1] XOR overflow; out_result = {0..., lt}; out_overflow = 0; out_cout = final carry.
  - AND/OR: cout = 0, overflow = 0.
  - Reserved op: out_result = 0, cout/overflow = 0, zero = 1. It still takes NIBBLES cycles.
  - out_zero is computed over the final out_result, including the SLT result.
- Latency: out_valid rises exactly NIBBLES cycles after the accept edge.
- DONE: out_* are held stable while out_valid & !out_ready. On the out_valid & out_ready edge, go to IDLE.
- Throughput: at most one op per NIBBLES+2 cycles. There is no accept in the same cycle as the response handshake.
- in_valid is ignored outside IDLE. No request is queued or lost: the requester holds it until in_ready.
- Reset mid-RUN or mid-DONE aborts the op. The response is never presented, and state returns to IDLE next cycle.
- out_result/flags keep the last response value until the next finalize. They are cleared only by reset.

Test Plan:
- Reset, then ADD a=0x7FFF b=0x0001 -> out_valid exactly 4 cycles after accept; result 0x8000, overflow 1, cout 0, zero 0.
- SUB a=0x0005 b=0x0005 -> result 0x0000, zero 1, cout 1, overflow 0; ADD 0xFFFF+0x0001 -> 0x0000, cout 1, zero 1, overflow 0.
- SLT a=0x8000 b=0x7FFF -> result 0x0001, overflow 0 (overflow-corrected); SLT a=0x0003 b=0xFFFF -> 0x0000, zero 1; SLT a=0xFFFF b=0x0001 -> 0x0001.
- AND 0xF0F0&0x3C3C -> 0x3030; OR 0xF0F0|0x0F0F -> 0xFFFF, cout 0, overflow 0; reserved op 011 -> 0x0000, zero 1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 and a new request -> outputs stable, in_ready 0, no accept. Release out_ready -> IDLE, the new request is accepted next cycle, and its result is correct.
- Assert reset for 1 cycle during RUN (index 2) -> no out_valid, in_ready 1 next cycle. A following ADD 0x1234+0x1111 -> 0x2345.
